// File: rtl/fifo_ctrl_pkg.sv
// Shared types and sizes for the transmit-FIFO write arbiter and its helpers.
package fifo_ctrl_pkg;

  typedef enum logic {IDLE, XFER} fwa_state_t;

  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int LEN_W      = 3;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr, with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  always_comb begin
    int unsigned p;
    pick  = '0;
    valid = 1'b0;
    p     = 32'(ptr);
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!valid && elig[i] && (i == (p + k) % N)) begin
          pick[i] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Whole-frame round-robin arbiter for the transmit-FIFO write port with space reservation.
// Optional sticky protocol-error output enabled by FWA_PROTOCOL_CHECK_EN.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DW     = 7,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int NREQ   = 2,
  parameter int MAXLEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*LEN_W-1:0]     req_len,
  input  logic [NREQ*(DW+1)-1:0]    req_data,
  output logic [NREQ-1:0]           byte_ack,
  output logic [NREQ-1:0]           frame_done,
  input  logic                      transmit_complete,
  input  logic                      full,
  output logic                      write,
  output logic [DW:0]               wr_data,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(DEPTH):0]    level
`ifdef FWA_PROTOCOL_CHECK_EN
  ,
  output logic                      err
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fwa_state_t        state;
  logic [LEN_W-1:0]  remaining;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [PW-1:0]     next_ptr;
  logic [LW-1:0]     free;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   illegal;
  logic [NREQ-1:0]   pick;
  logic              pick_valid;
  logic [LEN_W-1:0]  pick_len;
  logic              pop;

  assign free = LW'(DEPTH) - level;
  assign pop  = transmit_complete && (level != '0);

  always_comb begin
    logic [LEN_W-1:0] len;
    elig    = '0;
    illegal = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      len        = req_len[LEN_W*i +: LEN_W];
      illegal[i] = req[i] && ((len == '0) || (len > LEN_W'(MAXLEN)));
      elig[i]    = req[i] && !illegal[i] && (LW'(len) <= free);
    end
  end

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .elig  (elig),
    .ptr   (rr_ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_len = '0;
    gidx     = '0;
    wr_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i])  pick_len = req_len[LEN_W*i +: LEN_W];
      if (grant[i]) begin
        gidx    = PW'(i);
        wr_data = req_data[(DW+1)*i +: DW+1];
      end
    end
  end

  assign next_ptr   = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
  assign write      = (state == XFER) && !full;
  assign byte_ack   = write ? grant : '0;
  assign frame_done = (write && remaining == LEN_W'(1)) ? grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      remaining <= '0;
      rr_ptr    <= '0;
      level     <= '0;
    end else begin
      if (write && !pop)      level <= level + LW'(1);
      else if (!write && pop) level <= level - LW'(1);

      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant     <= pick;
            remaining <= pick_len;
            state     <= XFER;
          end
        end
        XFER: begin
          if (write) begin
            if (remaining == LEN_W'(1)) begin
              grant     <= '0;
              remaining <= '0;
              rr_ptr    <= next_ptr;
              state     <= IDLE;
            end else begin
              remaining <= remaining - LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FWA_PROTOCOL_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((illegal != '0) || (transmit_complete && level == '0) ||
                 (full && state == XFER) || (level == LW'(DEPTH) && !full)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, directed corner sequences, randomized run vs. frame-level model.
module tb_fifo_write_arbiter;
  import fifo_ctrl_pkg::*;

  localparam int DW     = 7;
  localparam int DEPTH  = 16;
  localparam int NREQ   = 2;
  localparam int MAXLEN = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*LEN_W-1:0]  req_len = '0;
  logic [NREQ*(DW+1)-1:0] req_data = '0;
  logic [NREQ-1:0]        byte_ack;
  logic [NREQ-1:0]        frame_done;
  logic                   transmit_complete = 1'b0;
  logic                   full = 1'b0;
  logic                   write;
  logic [DW:0]            wr_data;
  logic [NREQ-1:0]        grant;
  logic [LVL_W-1:0]       level;
`ifdef FWA_PROTOCOL_CHECK_EN
  logic                   err;
`endif

  fifo_write_arbiter #(.DW(DW), .DEPTH(DEPTH), .NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .req_len           (req_len),
    .req_data          (req_data),
    .byte_ack          (byte_ack),
    .frame_done        (frame_done),
    .transmit_complete (transmit_complete),
    .full              (full),
    .write             (write),
    .wr_data           (wr_data),
    .grant             (grant),
    .level             (level)
`ifdef FWA_PROTOCOL_CHECK_EN
    ,
    .err               (err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // producer state driven onto the request ports
  logic [1:0] p_req = '0;
  logic [2:0] p_len [2];
  logic [7:0] p_data [2];
  logic       tc_drv = 1'b0;

  // frame-level reference model
  bit m_busy;
  int m_owner, m_left, m_ptr, m_level;

  logic [1:0] dut_ack_seen, dut_done_seen, prev_grant;
  int         dut_order [$];

  typedef struct {
    logic [1:0] req;
    logic [2:0] len0;
    logic [7:0] d0;
    logic       tc;
    logic       e_w;
    logic [7:0] e_d;
    logic [1:0] e_ack;
    logic [1:0] e_done;
    logic [1:0] e_grant;
    logic [4:0] e_lvl;
  } vec_t;
  vec_t tv [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_level = 0;
    p_req = '0; tc_drv = 1'b0; prev_grant = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cycle();
    logic       e_w;
    logic [7:0] e_data;
    logic [1:0] e_ack, e_done, e_grant;
    int free, pick, nxt_level, i;
    req = p_req;
    req_len = {3'd0, p_len[1], p_len[0]};
    req_data = {p_data[1], p_data[0]};
    transmit_complete = tc_drv;
    full = (m_level >= DEPTH);
    @(negedge clk);
    e_w = m_busy && !full;
    e_ack = '0; e_done = '0; e_grant = '0; e_data = '0;
    if (m_busy) e_grant[m_owner] = 1'b1;
    if (e_w) begin
      e_ack[m_owner] = 1'b1;
      e_data = p_data[m_owner];
      if (m_left == 1) e_done[m_owner] = 1'b1;
    end
    chk("write", 32'(write), 32'(e_w));
    if (e_w) chk("wr_data", 32'(wr_data), 32'(e_data));
    chk("byte_ack", 32'(byte_ack), 32'(e_ack));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("level", 32'(level), 32'(m_level));
    dut_ack_seen  = dut_ack_seen | byte_ack;
    dut_done_seen = dut_done_seen | frame_done;
    if (grant != '0 && prev_grant == '0) dut_order.push_back(grant[1] ? 1 : 0);
    prev_grant = grant;
    nxt_level = m_level + (e_w ? 1 : 0) - ((tc_drv && m_level > 0) ? 1 : 0);
    if (m_busy) begin
      if (e_w) begin
        p_data[m_owner] = p_data[m_owner] + 8'd1;
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          p_req[m_owner] = 1'b0;
          m_ptr = (m_owner + 1) % NREQ;
        end
      end
    end else begin
      free = DEPTH - m_level;
      pick = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (pick < 0 && p_req[i] && p_len[i] >= 1 && p_len[i] <= MAXLEN && int'(p_len[i]) <= free)
          pick = i;
      end
      if (pick >= 0) begin
        m_busy = 1; m_owner = pick; m_left = int'(p_len[pick]);
      end
    end
    m_level = nxt_level;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int r, input logic [2:0] len);
    p_req[r] = 1'b1;
    p_len[r] = len;
    dut_done_seen = '0;
    for (int c = 0; c < 20 && !dut_done_seen[r]; c++) cycle();
    chk("frame_done_seen", 32'(dut_done_seen[r]), 32'd1);
    p_req[r] = 1'b0;
  endtask

  initial begin
    tv[0] = '{2'b01, 3'd3, 8'hA1, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 5'd0};
    tv[1] = '{2'b01, 3'd3, 8'hA1, 1'b0, 1'b1, 8'hA1, 2'b01, 2'b00, 2'b01, 5'd0};
    tv[2] = '{2'b01, 3'd3, 8'hA2, 1'b1, 1'b1, 8'hA2, 2'b01, 2'b00, 2'b01, 5'd1};
    tv[3] = '{2'b01, 3'd3, 8'hA3, 1'b0, 1'b1, 8'hA3, 2'b01, 2'b01, 2'b01, 5'd1};
    tv[4] = '{2'b00, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 5'd2};
    tv[5] = '{2'b00, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 5'd2};
    tv[6] = '{2'b00, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 5'd1};
    tv[7] = '{2'b00, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 5'd0};
    tv[8] = '{2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 5'd0};
    p_len[0] = '0; p_len[1] = '0; p_data[0] = '0; p_data[1] = '0;
    dut_ack_seen = '0; dut_done_seen = '0; prev_grant = '0;

    // reset values
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ack", 32'(byte_ack), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single frame plus simultaneous write/pop and pop at empty
    for (int k = 0; k < 9; k++) begin
      req = tv[k].req;
      req_len = {3'd0, tv[k].len0};
      req_data = {8'h00, tv[k].d0};
      transmit_complete = tv[k].tc;
      full = 1'b0;
      @(negedge clk);
      chk("tv_write", 32'(write), 32'(tv[k].e_w));
      chk("tv_wr_data", 32'(wr_data), 32'(tv[k].e_d));
      chk("tv_ack", 32'(byte_ack), 32'(tv[k].e_ack));
      chk("tv_done", 32'(frame_done), 32'(tv[k].e_done));
      chk("tv_grant", 32'(grant), 32'(tv[k].e_grant));
      chk("tv_level", 32'(level), 32'(tv[k].e_lvl));
      @(posedge clk); #1;
    end
`ifdef FWA_PROTOCOL_CHECK_EN
    chk("err_pop_empty", 32'(err), 32'd1);
`endif

    // round robin: 0 then 1 (rr_ptr=1 with both pending) then 0
    do_reset();
    dut_order.delete();
    p_req = 2'b11; p_len[0] = 3'd2; p_len[1] = 3'd2;
    for (int c = 0; c < 3; c++) cycle();
    p_req[0] = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    chk("rr_count", 32'(dut_order.size()), 32'd3);
    if (dut_order.size() == 3) begin
      chk("rr_first", 32'(dut_order[0]), 32'd0);
      chk("rr_second", 32'(dut_order[1]), 32'd1);
      chk("rr_third", 32'(dut_order[2]), 32'd0);
    end

    // space gating: preload 14, len 4 waits until two pops
    do_reset();
    run_frame(0, 3'd4); run_frame(0, 3'd4); run_frame(0, 3'd4); run_frame(0, 3'd2);
    chk("gate_preload", 32'(level), 32'd14);
    p_req[1] = 1'b1; p_len[1] = 3'd4;
    for (int c = 0; c < 3; c++) cycle();
    chk("gate_no_grant", 32'(grant), 32'd0);
    tc_drv = 1'b1; cycle(); cycle(); tc_drv = 1'b0;
    chk("gate_level12", 32'(level), 32'd12);
    cycle();
    chk("gate_granted", 32'(grant), 32'b10);
    dut_done_seen = '0;
    for (int c = 0; c < 10 && !dut_done_seen[1]; c++) cycle();
    chk("gate_done", 32'(dut_done_seen[1]), 32'd1);
    chk("gate_level16", 32'(level), 32'd16);

    // illegal length is never granted
    do_reset();
    dut_ack_seen = '0; dut_done_seen = '0;
    p_req = 2'b11; p_len[0] = 3'd0; p_len[1] = 3'd2;
    for (int c = 0; c < 6; c++) cycle();
    chk("illegal_never_acked", 32'(dut_ack_seen[0]), 32'd0);
    chk("illegal_other_served", 32'(dut_done_seen[1]), 32'd1);
`ifdef FWA_PROTOCOL_CHECK_EN
    chk("err_illegal_len", 32'(err), 32'd1);
`endif
    p_req[0] = 1'b0;

    // reset after second byte of a 4-byte frame
    do_reset();
    dut_done_seen = '0;
    p_req[0] = 1'b1; p_len[0] = 3'd4;
    for (int c = 0; c < 3; c++) cycle();
    chk("mid_level2", 32'(level), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_write", 32'(write), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_done", 32'(frame_done | dut_done_seen), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    run_frame(1, 3'd3);
    chk("after_rst_level", 32'(level), 32'd3);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!p_req[r] && $urandom_range(0, 3) == 0) begin
          p_req[r]  = 1'b1;
          p_len[r]  = 3'($urandom_range(1, MAXLEN));
          p_data[r] = 8'($urandom);
        end
      end
      tc_drv = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
